// File: rtl/phase_sampler.sv
// phase_sampler: run controller for the oscillator array that counts each oscillator's phase mismatches against oscillator 0
// over a sample window and latches the thresholded counts as spins.
module phase_sampler #(
  parameter int N = 8,
  parameter int WINDOW = 1024,
  parameter int SYNC_STAGES = 2,
  localparam int CNT_W = $clog2(WINDOW + 1),
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             axi_rst,
  input  logic             start,
  input  logic [31:0]      cfg_settle,
  input  logic [N-1:0]     osc_in,
  output logic             ising_rstn,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     spins,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_count
);
  typedef enum logic [1:0] {IDLE, RUN, SAMPLE, DONE} state_t;
  state_t           r_state, w_next;
  logic [31:0]      r_settle;
  logic [CNT_W-1:0] r_win;
  logic [CNT_W-1:0] r_cnt [N];
  logic [CNT_W-1:0] w_inc [N];
  logic [N-1:0]     r_sync [SYNC_STAGES];
  logic [N-1:0]     w_sync;
  logic [N-1:0]     r_spins;
  logic [CNT_W-1:0] r_rd;
  logic             w_enter_sample;
  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_enter_sample = (w_next == SAMPLE) && (r_state != SAMPLE);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = (cfg_settle != 32'd0) ? RUN : SAMPLE;
      RUN:        if (r_settle == 32'd1) w_next = SAMPLE;
      SAMPLE:     if (r_win == CNT_W'(WINDOW - 1)) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end
  // Count value including this cycle's comparison; also feeds the spin threshold on the final sample.
  always_comb begin
    for (int i = 0; i < N; i++)
      w_inc[i] = r_cnt[i] + CNT_W'((i != 0) && (w_sync[i] != w_sync[0]));
  end
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      r_state  <= IDLE;
      r_settle <= '0;
      r_win    <= '0;
      r_spins  <= '0;
      r_rd     <= '0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_state   <= w_next;
      r_sync[0] <= osc_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_settle  <= (r_state == RUN) ? r_settle - 32'd1 : cfg_settle;
      if (w_enter_sample) begin
        r_win <= '0;
        for (int i = 0; i < N; i++) r_cnt[i] <= '0;
      end else if (r_state == SAMPLE) begin
        r_win <= r_win + CNT_W'(1);
        for (int i = 0; i < N; i++) r_cnt[i] <= w_inc[i];
      end
      if (r_state == SAMPLE && w_next == DONE)
        for (int i = 0; i < N; i++) r_spins[i] <= w_inc[i] > CNT_W'(WINDOW / 2);
      r_rd <= (int'(rd_idx) < N) ? r_cnt[rd_idx] : '0;
    end
  end
  assign ising_rstn = r_state != IDLE;
  assign busy       = (r_state == RUN) || (r_state == SAMPLE);
  assign done       = r_state == DONE;
  assign spins      = r_spins;
  assign rd_count   = r_rd;
endmodule

// File: tb/tb_phase_sampler.sv
// tb_phase_sampler: random-stimulus bench; expected counts are rebuilt from a per-cycle history of osc_in
// and the synchroniser latency, then compared with spins and rd_count.
module tb_phase_sampler;
  localparam int N = 8;
  localparam int W = 16;
  localparam int SS = 2;
  logic        clk = 0;
  logic        axi_rst = 1;
  logic        start = 0;
  logic [31:0] cfg_settle = 0;
  logic [7:0]  osc_in = 0;
  logic        ising_rstn, busy, done;
  logic [7:0]  spins;
  logic [2:0]  rd_idx = 0;
  logic [4:0]  rd_count;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] hist [8192];
  int mode = 0;
  int ws = 1 << 30;
  int ndiff = 0;

  phase_sampler #(.N(N), .WINDOW(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .axi_rst(axi_rst), .start(start), .cfg_settle(cfg_settle),
    .osc_in(osc_in), .ising_rstn(ising_rstn), .busy(busy), .done(done),
    .spins(spins), .rd_idx(rd_idx), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  // osc_in for posedge number c is chosen at the preceding negedge
  always @(negedge clk) begin
    automatic int c = cyc + 1;
    automatic logic b = 1'($urandom);
    cyc <= c;
    case (mode)
      0: osc_in = {8{b}};
      1: osc_in = {8{b}} ^ 8'h08;
      2: osc_in = 8'($urandom);
      default: osc_in = {8{b}} ^ ((c >= ws && c < ws + ndiff) ? 8'h20 : 8'h00);
    endcase
  end

  always @(posedge clk) hist[cyc] <= osc_in;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int s, input int m, input int nd, input bit inject);
    int t0, j, bc, hold_bad;
    int ec [N];
    logic [7:0] prev, es, h;
    @(negedge clk);
    mode = m; ndiff = nd; ws = 1 << 30;
    start = 1; cfg_settle = 32'(s); prev = spins;
    @(posedge clk);
    t0 = cyc;
    if (m == 3) ws = t0 + s - 1;
    #1;
    start = 0;
    cfg_settle = 32'($urandom_range(1, 9));
    chk("rstn_run", int'(ising_rstn), 1);
    bc = int'(busy); hold_bad = 0; j = 0;
    while (j < 100) begin
      @(posedge clk); #1;
      j++;
      start = inject && j == 3;
      if (done) break;
      bc += int'(busy);
      if (spins != prev) hold_bad++;
    end
    start = 0;
    chk("done_cycle", j, s + W);
    chk("busy_cycles", bc, s + W);
    chk("spins_hold", hold_bad, 0);
    es = '0;
    for (int i = 0; i < N; i++) begin
      ec[i] = 0;
      for (int k = 0; k < W; k++) begin
        h = hist[t0 + s + k + 1 - SS];
        if (h[i] != h[0]) ec[i]++;
      end
      es[i] = ec[i] > W / 2;
    end
    chk("spins", int'(spins), int'(es));
    chk("rstn_done", int'(ising_rstn), 1);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      rd_idx = 3'(i);
      @(posedge clk); #1;
      chk($sformatf("cnt%0d", i), int'(rd_count), ec[i]);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rstn", int'(ising_rstn), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_spins", int'(spins), 0);
    chk("rst_rdcount", int'(rd_count), 0);
    @(negedge clk);
    axi_rst = 0;
    run(5, 0, 0, 0);
    run(3, 1, 0, 0);
    chk("spins_inv3", int'(spins), 8);
    run(2, 3, 8, 0);
    chk("spin5_eq_half", int'(spins[5]), 0);
    run(2, 3, 9, 0);
    chk("spin5_over_half", int'(spins[5]), 1);
    run(0, 2, 0, 1);
    run(2, 2, 0, 0);
    repeat (6) run($urandom_range(0, 6), 2, 0, 0);
    run(1, 1, 0, 0);
    @(negedge clk);
    mode = 1; start = 1; cfg_settle = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    axi_rst = 1; rd_idx = 3;
    @(posedge clk); #1;
    chk("mid_rst_rstn", int'(ising_rstn), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_spins", int'(spins), 0);
    chk("mid_rst_rdcount", int'(rd_count), 0);
    @(negedge clk);
    axi_rst = 0;
    run(2, 2, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
